// File: rtl/n64adv_vdemux_vinfo.sv
// Demultiplexes N64 sync/R/G/B words and tracks lines per field, PAL mode and interlace.
// Outputs register one cycle after B; no backpressure (VCLK-paced stream, idle gaps held in phase 0).
module n64adv_vdemux_vinfo #(
  parameter int                    color_width_i = 7,
  parameter int                    color_width_o = 8,
  parameter int                    line_cnt_w    = 10,
  parameter logic [line_cnt_w-1:0] pal_thresh    = 10'd280
) (
  input  logic                       VCLK,
  input  logic                       nVRST,
  input  logic                       nVDSYNC,
  input  logic [color_width_i-1:0]   VD_i,
  output logic                       vdata_valid_o,
  output logic [3:0]                 vsync_vec_o,
  output logic [3*color_width_o-1:0] RGB_o,
  output logic [1:0]                 vinfo_o,
  output logic [line_cnt_w-1:0]      line_cnt_o,
  output logic                       phase_err_o
);

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_R    = 2'd1,
    PH_G    = 2'd2,
    PH_B    = 2'd3
  } phase_e;

  localparam int XW = color_width_o - color_width_i;

  phase_e                       phase_q, phase_d;
  logic [3:0]                   sync_q, sync_d;
  logic [color_width_i-1:0]     r_q, r_d, g_q, g_d;
  logic                         valid_q, valid_d;
  logic                         err_q, err_d;
  logic [3:0]                   vvec_q, vvec_d;
  logic [3*color_width_o-1:0]   rgb_q, rgb_d;
  logic                         pal_q, pal_d;
  logic                         il_q, il_d;
  logic [line_cnt_w-1:0]        lcnt_q, lcnt_d;
  logic [line_cnt_w-1:0]        cnt_q, cnt_d;
  logic                         prev_hs_q, prev_hs_d;
  logic                         prev_vs_q, prev_vs_d;
  logic                         field_hs_q, field_hs_d;

  logic [color_width_o-1:0]     r_x, g_x, b_x;
  logic [line_cnt_w-1:0]        cnt_inc;

  // Low bits are refilled from the channel MSBs so full scale maps to full scale.
  generate
    if (XW == 0) begin : g_ident
      assign r_x = r_q;
      assign g_x = g_q;
      assign b_x = VD_i;
    end else begin : g_expand
      assign r_x = {r_q,  r_q[color_width_i-1 -: XW]};
      assign g_x = {g_q,  g_q[color_width_i-1 -: XW]};
      assign b_x = {VD_i, VD_i[color_width_i-1 -: XW]};
    end
  endgenerate

  always_comb begin
    phase_d    = phase_q;
    sync_d     = sync_q;
    r_d        = r_q;
    g_d        = g_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    vvec_d     = vvec_q;
    rgb_d      = rgb_q;
    pal_d      = pal_q;
    il_d       = il_q;
    lcnt_d     = lcnt_q;
    cnt_d      = cnt_q;
    prev_hs_d  = prev_hs_q;
    prev_vs_d  = prev_vs_q;
    field_hs_d = field_hs_q;
    cnt_inc    = cnt_q;

    if (!nVDSYNC) begin
      err_d   = (phase_q != PH_SYNC);
      sync_d  = VD_i[3:0];
      phase_d = PH_R;
    end else begin
      case (phase_q)
        PH_SYNC: ;
        PH_R: begin
          r_d     = VD_i;
          phase_d = PH_G;
        end
        PH_G: begin
          g_d     = VD_i;
          phase_d = PH_B;
        end
        PH_B: begin
          phase_d = PH_SYNC;
          valid_d = 1'b1;
          vvec_d  = sync_q;
          rgb_d   = {r_x, g_x, b_x};
          // sync_q = {nVSYNC, nCLAMP, nHSYNC, nCSYNC}; line is counted before a coincident field latch
          if (prev_hs_q && !sync_q[1] && !(&cnt_q))
            cnt_inc = cnt_q + 1'b1;
          cnt_d = cnt_inc;
          if (prev_vs_q && !sync_q[3]) begin
            lcnt_d     = cnt_inc;
            pal_d      = (cnt_inc >= pal_thresh);
            cnt_d      = '0;
            il_d       = (sync_q[1] != field_hs_q);
            field_hs_d = sync_q[1];
          end
          prev_hs_d = sync_q[1];
          prev_vs_d = sync_q[3];
        end
      endcase
    end
  end

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      phase_q    <= PH_SYNC;
      sync_q     <= 4'hF;
      r_q        <= '0;
      g_q        <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      vvec_q     <= 4'hF;
      rgb_q      <= '0;
      pal_q      <= 1'b0;
      il_q       <= 1'b0;
      lcnt_q     <= '0;
      cnt_q      <= '0;
      prev_hs_q  <= 1'b1;
      prev_vs_q  <= 1'b1;
      field_hs_q <= 1'b1;
    end else begin
      phase_q    <= phase_d;
      sync_q     <= sync_d;
      r_q        <= r_d;
      g_q        <= g_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      vvec_q     <= vvec_d;
      rgb_q      <= rgb_d;
      pal_q      <= pal_d;
      il_q       <= il_d;
      lcnt_q     <= lcnt_d;
      cnt_q      <= cnt_d;
      prev_hs_q  <= prev_hs_d;
      prev_vs_q  <= prev_vs_d;
      field_hs_q <= field_hs_d;
    end
  end

  assign vdata_valid_o = valid_q;
  assign phase_err_o   = err_q;
  assign vsync_vec_o   = vvec_q;
  assign RGB_o         = rgb_q;
  assign vinfo_o       = {pal_q, il_q};
  assign line_cnt_o    = lcnt_q;

endmodule

// File: tb/tb_n64adv_vdemux_vinfo.sv
// Directed stimulus with a queue-based scoreboard checked by an independent monitor.
module tb_n64adv_vdemux_vinfo;

  logic        VCLK = 1'b0;
  logic        nVRST;
  logic        nVDSYNC;
  logic [6:0]  VD_i;
  logic        vdata_valid_o;
  logic [3:0]  vsync_vec_o;
  logic [23:0] RGB_o;
  logic [1:0]  vinfo_o;
  logic [9:0]  line_cnt_o;
  logic        phase_err_o;

  n64adv_vdemux_vinfo dut (
    .VCLK          (VCLK),
    .nVRST         (nVRST),
    .nVDSYNC       (nVDSYNC),
    .VD_i          (VD_i),
    .vdata_valid_o (vdata_valid_o),
    .vsync_vec_o   (vsync_vec_o),
    .RGB_o         (RGB_o),
    .vinfo_o       (vinfo_o),
    .line_cnt_o    (line_cnt_o),
    .phase_err_o   (phase_err_o)
  );

  always #5 VCLK = ~VCLK;

  typedef struct {
    bit          is_err;
    logic [3:0]  vs;
    logic [23:0] rgb;
    logic [1:0]  vi;
    logic [9:0]  lc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [1:0] exp_vinfo = 2'b00;
  logic [9:0] exp_lcnt  = 10'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every strobe must match the next scoreboard entry.
  always @(negedge VCLK) begin
    if (vdata_valid_o || phase_err_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output valid=%0b err=%0b at %0t", vdata_valid_o, phase_err_o, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_err) begin
          chk("phase_err", {31'd0, phase_err_o}, 32'd1);
          chk("valid_on_err", {31'd0, vdata_valid_o}, 32'd0);
        end else begin
          chk("valid", {31'd0, vdata_valid_o}, 32'd1);
          chk("err_on_word", {31'd0, phase_err_o}, 32'd0);
          chk("vsync_vec", {28'd0, vsync_vec_o}, {28'd0, e.vs});
          chk("rgb", {8'd0, RGB_o}, {8'd0, e.rgb});
          chk("vinfo", {30'd0, vinfo_o}, {30'd0, e.vi});
          chk("line_cnt", {22'd0, line_cnt_o}, {22'd0, e.lc});
        end
      end
    end
  end

  task automatic cyc(input logic nd, input logic [6:0] vd);
    nVDSYNC = nd;
    VD_i    = vd;
    @(posedge VCLK);
    #1;
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.vs = 4'h0; e.rgb = 24'h0; e.vi = 2'b00; e.lc = 10'd0;
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [3:0] sync, input logic [6:0] r, input logic [6:0] g,
                           input logic [6:0] b, input logic [23:0] rgb_exp);
    exp_t e;
    logic [6:0] sv;
    e.is_err = 1'b0; e.vs = sync; e.rgb = rgb_exp; e.vi = exp_vinfo; e.lc = exp_lcnt;
    exp_q.push_back(e);
    sv = {3'b000, sync};
    cyc(1'b0, sv);
    cyc(1'b1, r);
    cyc(1'b1, g);
    cyc(1'b1, b);
  endtask

  initial begin
    nVRST   = 1'b0;
    nVDSYNC = 1'b1;
    VD_i    = 7'h00;
    repeat (3) @(posedge VCLK);
    #1;
    chk("rst_valid", {31'd0, vdata_valid_o}, 32'd0);
    chk("rst_err", {31'd0, phase_err_o}, 32'd0);
    chk("rst_vsync", {28'd0, vsync_vec_o}, 32'hF);
    chk("rst_rgb", {8'd0, RGB_o}, 32'd0);
    chk("rst_vinfo", {30'd0, vinfo_o}, 32'd0);
    chk("rst_lcnt", {22'd0, line_cnt_o}, 32'd0);
    nVRST = 1'b1;
    cyc(1'b1, 7'h00);

    // Back-to-back word with expansion boundaries
    send_word(4'hF, 7'h7F, 7'h00, 7'h41, 24'hFF0083);
    cyc(1'b1, 7'h00);

    // Broken word: sync lands in the G slot
    cyc(1'b0, 7'h0F);
    cyc(1'b1, 7'h10);
    push_err();
    send_word(4'hF, 7'h01, 7'h40, 7'h3F, 24'h02817E);

    // Idle gaps of 1..5 cycles
    for (int gap = 1; gap <= 5; gap++) begin
      for (int k = 0; k < gap; k++) cyc(1'b1, 7'h5A);
      send_word(4'hF, 7'h00, 7'h7F, 7'h2A, 24'h00FF54);
    end

    // Field start: vsync with nHSYNC high matches reset history
    send_word(4'h7, 7'h00, 7'h00, 7'h00, 24'h0);
    // 311 lines plus one coincident with vsync -> 312, PAL, parity 0 vs 1
    for (int i = 0; i < 311; i++) begin
      send_word(4'hD, 7'h00, 7'h00, 7'h00, 24'h0);
      send_word(4'hF, 7'h00, 7'h00, 7'h00, 24'h0);
    end
    exp_vinfo = 2'b11; exp_lcnt = 10'd312;
    send_word(4'h5, 7'h00, 7'h00, 7'h00, 24'h0);
    // 262 lines, vsync with nHSYNC high -> NTSC, parity changed
    for (int i = 0; i < 262; i++) begin
      send_word(4'hF, 7'h00, 7'h00, 7'h00, 24'h0);
      send_word(4'hD, 7'h00, 7'h00, 7'h00, 24'h0);
    end
    exp_vinfo = 2'b01; exp_lcnt = 10'd262;
    send_word(4'h7, 7'h00, 7'h00, 7'h00, 24'h0);
    // Same parity again -> progressive
    for (int i = 0; i < 5; i++) begin
      send_word(4'hD, 7'h00, 7'h00, 7'h00, 24'h0);
      send_word(4'hF, 7'h00, 7'h00, 7'h00, 24'h0);
    end
    exp_vinfo = 2'b00; exp_lcnt = 10'd5;
    send_word(4'h7, 7'h7F, 7'h7F, 7'h7F, 24'hFFFFFF);

    // Reset asserted after R of a word
    cyc(1'b0, 7'h0F);
    cyc(1'b1, 7'h55);
    nVRST = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, vdata_valid_o}, 32'd0);
    chk("mid_rst_err", {31'd0, phase_err_o}, 32'd0);
    chk("mid_rst_vsync", {28'd0, vsync_vec_o}, 32'hF);
    chk("mid_rst_rgb", {8'd0, RGB_o}, 32'd0);
    chk("mid_rst_vinfo", {30'd0, vinfo_o}, 32'd0);
    chk("mid_rst_lcnt", {22'd0, line_cnt_o}, 32'd0);
    repeat (2) @(posedge VCLK);
    #1;
    nVRST = 1'b1;
    exp_vinfo = 2'b00; exp_lcnt = 10'd0;
    cyc(1'b1, 7'h22);
    cyc(1'b1, 7'h33);
    cyc(1'b1, 7'h44);
    cyc(1'b1, 7'h00);
    send_word(4'hF, 7'h41, 7'h7F, 7'h00, 24'h83FF00);

    repeat (4) cyc(1'b1, 7'h00);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/n64adv_vdemux_vinfo.md
N64ADV_VDEMUX_VINFO -- requirements
Module: n64adv_vdemux_vinfo

Interface
REQ-001 SHALL provide parameter color_width_i, default 7, meaning N64 input colour width per channel.
REQ-002 SHALL provide parameter color_width_o, default 8, meaning output colour width per channel; legal range color_width_i..2*color_width_i.
REQ-003 SHALL provide parameter line_cnt_w, default 10, meaning line counter width.
REQ-004 SHALL provide parameter pal_thresh, default 10'd280, meaning lines-per-field threshold at or above which the field is PAL.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named VCLK and nVRST.
REQ-006 SHALL have port VCLK, input, 1, N64 video clock; all logic on rising edge.
REQ-007 SHALL have port nVRST, input, 1, async active-low reset.
REQ-008 SHALL have port nVDSYNC, input, 1, low marks the sync phase of a data word.
REQ-009 SHALL have port VD_i, input, color_width_i, multiplexed N64 video bus.
REQ-010 SHALL have port vdata_valid_o, output, 1, one-cycle strobe for a complete word.
REQ-011 SHALL have port vsync_vec_o, output, 4, {nVSYNC,nCLAMP,nHSYNC,nCSYNC} of the current word.
REQ-012 SHALL have port RGB_o, output, 3*color_width_o, {R,G,B} expanded colour.
REQ-013 SHALL have port vinfo_o, output, 2, {palmode, interlaced}.
REQ-014 SHALL have port line_cnt_o, output, line_cnt_w, lines counted in the last completed field.
REQ-015 SHALL have port phase_err_o, output, 1, one-cycle strobe on a broken word.

Function
REQ-016 SHALL keep a 2-bit phase counter: idle/sync=0, R=1, G=2, B=3.
REQ-017 SHALL, on nVDSYNC=0, capture VD_i[3:0] as sync bits and set phase to 1, regardless of current phase.
REQ-018 SHALL, with nVDSYNC=1 and phase 1/2/3, capture VD_i as R/G/B respectively and advance phase (3 wraps to 0).
REQ-019 SHALL, with nVDSYNC=1 and phase 0, hold all state (idle gaps legal, no error).
REQ-020 SHALL update vsync_vec_o and RGB_o and pulse vdata_valid_o in the cycle after B is sampled (latency 1 cycle from B); outputs hold between strobes.
REQ-021 SHALL pulse phase_err_o when nVDSYNC=0 arrives in phase 1 or 2 or 3 (mid-word), discard the partial word, produce no vdata_valid_o for it, and start the new word.
REQ-022 SHALL expand each channel as {c, c[color_width_i-1 -: color_width_o-color_width_i]}; identity when widths are equal.
REQ-023 SHALL, per valid word, detect nHSYNC falling edge versus the previous valid word and increment the line counter, saturating at all-ones.
REQ-024 SHALL, on nVSYNC falling edge (valid-word basis), latch line_cnt_o from the counter, set palmode = (counter >= pal_thresh), clear the counter to 0.
REQ-025 SHALL, on the same nVSYNC edge, sample nHSYNC of that word; interlaced = 1 if it differs from the sample of the previous field, else 0.
REQ-026 SHALL, if hsync and vsync edges coincide in one word, count the line first then latch and clear (counter becomes 0).

Reset
REQ-027 SHALL, while nVRST=0, force phase=0, vdata_valid_o=0, phase_err_o=0, vsync_vec_o=4'hF, RGB_o=0, vinfo_o=2'b00, line_cnt_o=0, counter=0, previous-sync and field-parity history to inactive (1).
REQ-028 SHALL, on reset asserted mid-word, discard the partial word; first word after release begins only at nVDSYNC=0.

Verification
REQ-029 SHALL cover: sync 4'hF, R=7'h7F, G=7'h00, B=7'h41 back-to-back -> one strobe one cycle after B, RGB_o={8'hFF,8'h00,8'h83}, vsync_vec_o=4'hF.
REQ-030 SHALL cover: nVDSYNC low during G phase -> phase_err_o one pulse, no strobe for broken word, next full word output correctly.
REQ-031 SHALL cover: 312 hsync falling edges between vsync edges -> line_cnt_o=312, palmode=1; then 262 -> line_cnt_o=262, palmode=0.
REQ-032 SHALL cover: alternating fields with nHSYNC 0 then 1 at vsync edge -> interlaced=1; two equal fields -> interlaced=0.
REQ-033 SHALL cover: nVRST asserted after R of a word -> all outputs at reset values immediately; after release, stray G/B cycles without nVDSYNC produce no strobe.
REQ-034 SHALL cover: idle gaps of 1..5 cycles between words -> no phase_err_o, every word strobed exactly once.
